// File: rtl/ballot_machine.sv
// ---------------------------------------------------------------------------
// ballot_machine
//   Single-session electronic ballot box. A voter ID is checked against a
//   used-ID register. A verified voter then has TIMEOUT cycles to pick a
//   candidate, and the vote is committed into a saturating per-candidate
//   tally. close_poll freezes everything until reset.
//
//   Timing: every status/pulse output is registered. vote_done and
//   vote_error are high for the one cycle after the edge that decides them.
//   The tally update and vote_done become visible together.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous reset, active low
//   id           : voter ID, sampled with check in IDLE
//   check        : request verification of id
//   vote_signal  : cast a vote for candidate while a session is open
//   candidate    : selected candidate index
//   close_poll   : permanently close the poll (until reset)
//   votes_flat   : tallies, candidate k at [k*CNT_W +: CNT_W]
//   id_valid     : a verified voter is in session
//   id_used      : the last verified ID had already voted
//   vote_done    : one-cycle pulse, vote committed
//   vote_error   : one-cycle pulse, rejected ID / bad candidate / timeout
//   poll_closed  : poll is closed
//   leader       : lowest candidate index holding the maximum tally
//   tie          : two or more candidates share the maximum tally
// ---------------------------------------------------------------------------
module ballot_machine #(
   parameter  int ID_W       = 4,
   parameter  int NUM_VOTERS = 16,
   parameter  int NUM_CAND   = 4,
   parameter  int CNT_W      = 8,
   parameter  int TIMEOUT    = 15,
   localparam int CSEL_W     = $clog2(NUM_CAND)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ID_W-1:0]           id,
   input  logic                      check,
   input  logic                      vote_signal,
   input  logic [CSEL_W-1:0]         candidate,
   input  logic                      close_poll,
   output logic [NUM_CAND*CNT_W-1:0] votes_flat,
   output logic                      id_valid,
   output logic                      id_used,
   output logic                      vote_done,
   output logic                      vote_error,
   output logic                      poll_closed,
   output logic [CSEL_W-1:0]         leader,
   output logic                      tie
);

   localparam int TIM_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      VERIFY,
      WAIT_VOTE,
      COMMIT,
      CLOSED
   } state_t;

   state_t                r_state;
   logic [ID_W-1:0]       r_id;
   logic [CSEL_W-1:0]     r_cand;
   logic [TIM_W-1:0]      r_timer;
   logic [NUM_VOTERS-1:0] r_used;
   logic [CNT_W-1:0]      r_tally [NUM_CAND];

   logic r_id_valid;
   logic r_id_used;
   logic r_vote_done;
   logic r_vote_error;
   logic r_poll_closed;

   logic              w_id_in_range;
   logic              w_id_was_used;
   logic              w_cand_in_range;
   logic [CNT_W-1:0]  w_max;
   logic [CSEL_W-1:0] w_leader;
   logic              w_tie;

   // ------------------------------------------------------------------------
   // Decode helpers
   // ------------------------------------------------------------------------
   assign w_id_in_range   = (int'(r_id) < NUM_VOTERS);
   assign w_cand_in_range = (int'(candidate) < NUM_CAND);

   // Loop lookup keeps the used-bit read safe for out-of-range IDs.
   always_comb begin
      w_id_was_used = 1'b0;
      for (int v = 0; v < NUM_VOTERS; v++) begin
         if (int'(r_id) == v) begin
            w_id_was_used = r_used[v];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Standings: strict '>' keeps the lowest index on equal counts.
   // ------------------------------------------------------------------------
   always_comb begin
      w_max    = r_tally[0];
      w_leader = '0;
      for (int k = 1; k < NUM_CAND; k++) begin
         if (r_tally[k] > w_max) begin
            w_max    = r_tally[k];
            w_leader = CSEL_W'(k);
         end
      end
      w_tie = 1'b0;
      for (int k = 0; k < NUM_CAND; k++) begin
         if ((k != int'(w_leader)) && (r_tally[k] == w_max)) begin
            w_tie = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_id          <= '0;
         r_cand        <= '0;
         r_timer       <= '0;
         r_used        <= '0;
         r_id_valid    <= 1'b0;
         r_id_used     <= 1'b0;
         r_vote_done   <= 1'b0;
         r_vote_error  <= 1'b0;
         r_poll_closed <= 1'b0;
         for (int k = 0; k < NUM_CAND; k++) begin
            r_tally[k] <= '0;
         end
      end else begin
         // Pulses default low; each branch below raises at most one of them.
         r_vote_done  <= 1'b0;
         r_vote_error <= 1'b0;

         case (r_state)
            IDLE: begin
               if (close_poll) begin
                  r_state       <= CLOSED;
                  r_poll_closed <= 1'b1;
               end else if (check) begin
                  r_id    <= id;
                  r_state <= VERIFY;
               end
            end

            VERIFY: begin
               if (close_poll) begin
                  r_state       <= CLOSED;
                  r_poll_closed <= 1'b1;
               end else if (!w_id_in_range) begin
                  r_id_used    <= 1'b0;
                  r_vote_error <= 1'b1;
                  r_state      <= IDLE;
               end else if (w_id_was_used) begin
                  r_id_used    <= 1'b1;
                  r_vote_error <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_id_valid <= 1'b1;
                  r_id_used  <= 1'b0;
                  r_timer    <= TIM_W'(TIMEOUT);
                  r_state    <= WAIT_VOTE;
               end
            end

            WAIT_VOTE: begin
               if (close_poll) begin
                  r_state       <= CLOSED;
                  r_poll_closed <= 1'b1;
                  r_id_valid    <= 1'b0;
                  r_timer       <= '0;
               end else if (vote_signal && w_cand_in_range) begin
                  r_cand  <= candidate;
                  r_timer <= '0;
                  r_state <= COMMIT;
               end else if (r_timer == TIM_W'(1)) begin
                  // Last allowed cycle passed without a valid vote; the ID
                  // stays unused so the voter may try again.
                  r_vote_error <= 1'b1;
                  r_id_valid   <= 1'b0;
                  r_timer      <= '0;
                  r_state      <= IDLE;
               end else begin
                  r_timer <= r_timer - TIM_W'(1);
                  if (vote_signal) begin
                     r_vote_error <= 1'b1;
                  end
               end
            end

            COMMIT: begin
               for (int k = 0; k < NUM_CAND; k++) begin
                  if ((int'(r_cand) == k) && (r_tally[k] != {CNT_W{1'b1}})) begin
                     r_tally[k] <= r_tally[k] + CNT_W'(1);
                  end
               end
               for (int v = 0; v < NUM_VOTERS; v++) begin
                  if (int'(r_id) == v) begin
                     r_used[v] <= 1'b1;
                  end
               end
               r_vote_done <= 1'b1;
               r_id_valid  <= 1'b0;
               if (close_poll) begin
                  r_state       <= CLOSED;
                  r_poll_closed <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end

            CLOSED: begin
               r_state <= CLOSED;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      votes_flat = '0;
      for (int k = 0; k < NUM_CAND; k++) begin
         votes_flat[k*CNT_W +: CNT_W] = r_tally[k];
      end
   end

   assign id_valid    = r_id_valid;
   assign id_used     = r_id_used;
   assign vote_done   = r_vote_done;
   assign vote_error  = r_vote_error;
   assign poll_closed = r_poll_closed;
   assign leader      = w_leader;
   assign tie         = w_tie;

endmodule

// File: doc/ballot_machine.md
BALLOT_MACHINE -- requirements
Module: ballot_machine

Interface
REQ-001 SHALL have parameter ID_W, default 4, meaning voter ID width.
REQ-002 SHALL have parameter NUM_VOTERS, default 16 (<= 2^ID_W), meaning IDs 0..NUM_VOTERS-1 are valid.
REQ-003 SHALL have parameter NUM_CAND, default 4 (>= 2), meaning candidate count; CSEL_W = clog2(NUM_CAND).
REQ-004 SHALL have parameter CNT_W, default 8, meaning per-candidate tally width.
REQ-005 SHALL have parameter TIMEOUT, default 15 (>= 1), meaning cycles allowed between ID acceptance and vote.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, meaning asynchronous active-low reset (0 = reset asserted).
REQ-008 SHALL have port id, input, ID_W, meaning the voter ID, sampled when check=1.
REQ-009 SHALL have port check, input, 1, meaning request ID verification.
REQ-010 SHALL have port vote_signal, input, 1, meaning cast vote.
REQ-011 SHALL have port candidate, input, CSEL_W, meaning the candidate selected, sampled with vote_signal.
REQ-012 SHALL have port close_poll, input, 1, meaning permanently close voting.
REQ-013 SHALL have port votes_flat, output, NUM_CAND*CNT_W, meaning tallies; candidate k at bits [k*CNT_W +: CNT_W].
REQ-014 SHALL have port id_valid, output, 1, meaning a verified voter is in session.
REQ-015 SHALL have port id_used, output, 1, meaning the last checked ID had already voted.
REQ-016 SHALL have port vote_done, output, 1, meaning a one-cycle pulse on vote commit.
REQ-017 SHALL have port vote_error, output, 1, meaning a one-cycle pulse on a rejected ID, an out-of-range candidate, or a timeout.
REQ-018 SHALL have ports poll_closed (1), leader (CSEL_W) and tie (1), all outputs, meaning poll status and standings.

Function
REQ-019 FSM states SHALL be IDLE, VERIFY, WAIT_VOTE, COMMIT, CLOSED.
REQ-020 IDLE: check=1 SHALL latch id and go to VERIFY next cycle; vote_signal SHALL be ignored in IDLE.
REQ-021 VERIFY (1 cycle): if latched id >= NUM_VOTERS, SHALL pulse vote_error and return to IDLE.
REQ-022 VERIFY: if the used bit for the id is set, SHALL set id_used=1, pulse vote_error, and return to IDLE.
REQ-023 VERIFY: otherwise SHALL set id_valid=1, clear id_used, load the timer with TIMEOUT, and go to WAIT_VOTE.
REQ-024 WAIT_VOTE: vote_signal=1 with candidate < NUM_CAND SHALL latch the candidate and go to COMMIT.
REQ-025 WAIT_VOTE: vote_signal=1 with candidate >= NUM_CAND SHALL pulse vote_error and stay in WAIT_VOTE without reloading the timer.
REQ-026 WAIT_VOTE: the timer SHALL decrement each cycle; on reaching 0 without a vote, SHALL pulse vote_error, clear id_valid, return to IDLE, and leave the id unused.
REQ-027 WAIT_VOTE: check SHALL be ignored.
REQ-028 COMMIT (1 cycle): SHALL increment the selected tally saturating at 2^CNT_W-1, set the used bit, pulse vote_done, clear id_valid, and go to IDLE.
REQ-029 The ID can therefore be checked again on the cycle after the vote_done pulse.
REQ-030 close_poll=1 in IDLE, VERIFY or WAIT_VOTE SHALL go to CLOSED next cycle, abandoning the session with no tally change and no vote_error.
REQ-031 close_poll=1 in COMMIT SHALL complete the commit and then enter CLOSED.
REQ-032 CLOSED SHALL be terminal until reset; poll_closed=1; check and vote_signal ignored; tallies frozen.
REQ-033 leader SHALL be combinational from the tallies: the lowest index holding the maximum count.
REQ-034 tie SHALL be 1 when two or more candidates share the maximum count, including the all-zero case.
REQ-035 vote_done and vote_error SHALL never be asserted in the same cycle.
REQ-036 Used-ID storage SHALL be a NUM_VOTERS-bit register.

Reset
REQ-037 reset=0 SHALL asynchronously force IDLE and clear all tallies, used bits and the timer.
REQ-038 reset=0 SHALL drive id_valid, id_used, vote_done, vote_error and poll_closed to 0, leader to 0 and tie to 1.
REQ-039 Reset asserted mid-session SHALL discard the session with no tally change.
REQ-040 Release of reset SHALL take effect on the first rising clk edge after reset returns to 1.

Verification
REQ-041 Default parameters, id=3, check, then vote_signal with candidate=2 two cycles after check -> vote_done pulse; votes_flat[23:16]=1; id_valid falls.
REQ-042 After REQ-041, re-check id=3 -> id_used=1, vote_error pulse, tallies unchanged.
REQ-043 NUM_CAND=3, valid id, vote with candidate=3 -> vote_error pulse; then candidate=0 -> tally0=1.
REQ-044 Valid id with no vote for 15 cycles -> vote_error pulse, return to IDLE; the same id is then accepted on re-check.
REQ-045 CNT_W=2, four votes for candidate 1 from distinct ids -> tally1 saturates at 3; leader=1, tie=0.
REQ-046 close_poll during WAIT_VOTE -> poll_closed=1, later checks ignored; reset=0 -> all tallies 0, tie=1.
